// File: rtl/ram_cmd_initiator.sv
// Host-side initiator framing write/read requests as 10-bit SPI-RAM commands.
// Define RAM_CMD_NO_GAP_EN to issue the second command word back-to-back.
module ram_cmd_initiator #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy,
   output logic [9:0] din,
   output logic       rx_valid,
   input  logic [7:0] dout,
   input  logic       tx_valid
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD1 = 3'd1,
      GAP  = 3'd2,
      CMD2 = 3'd3,
      WAIT = 3'd4,
      RSP  = 3'd5
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

   state_t     r_state;
   logic       r_write;
   logic [7:0] r_wdata;
   logic [7:0] r_cnt;
   logic       r_req_ready;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_rdata;
   logic       r_rsp_err;
   logic       r_busy;
   logic [9:0] r_din;
   logic       r_rx_valid;
   logic [9:0] w_cmd2;

   assign w_cmd2 = r_write ? {2'b01, r_wdata} : {2'b11, 8'h00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_wdata     <= 8'h00;
         r_cnt       <= 8'h00;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 8'h00;
         r_rsp_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_din       <= 10'h000;
         r_rx_valid  <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_rsp_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_req_ready <= 1'b1;
               if (r_req_ready && req_valid) begin
                  r_write     <= req_write;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_rx_valid  <= 1'b1;
                  r_din       <= {req_write ? 2'b00 : 2'b10, req_addr};
                  r_state     <= CMD1;
               end
            end
            CMD1: begin
`ifdef RAM_CMD_NO_GAP_EN
               r_rx_valid <= 1'b1;
               r_din      <= w_cmd2;
               r_state    <= CMD2;
`else
               r_state    <= GAP;
`endif
            end
            GAP: begin
               r_rx_valid <= 1'b1;
               r_din      <= w_cmd2;
               r_state    <= CMD2;
            end
            CMD2: begin
               if (r_write) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 8'h00;
                  r_rsp_err   <= 1'b0;
                  r_state     <= RSP;
               end else begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               // a response on the last wait cycle still beats the timeout
               if (tx_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= dout;
                  r_rsp_err   <= 1'b0;
                  r_state     <= RSP;
               end else if (r_cnt == LP_LAST) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 8'h00;
                  r_rsp_err   <= 1'b1;
                  r_state     <= RSP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            RSP: begin
               r_cnt       <= 8'h00;
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;
   assign din       = r_din;
   assign rx_valid  = r_rx_valid;

endmodule

// File: tb/tb_ram_cmd_initiator.sv
// Randomized bench for ram_cmd_initiator against a cycle-offset reference model.
// Honours RAM_CMD_NO_GAP_EN for the back-to-back command build.
module tb_ram_cmd_initiator;

   localparam int T = 16;
`ifdef RAM_CMD_NO_GAP_EN
   localparam int C2 = 2;
`else
   localparam int C2 = 3;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       busy;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   int n_chk  = 0;
   int n_pass = 0;
   logic [7:0] m_rdata;
   logic       m_err;

   always #5 clk = ~clk;

   ram_cmd_initiator #(.TIMEOUT(T)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .din       (din),
      .rx_valid  (rx_valid),
      .dout      (dout),
      .tx_valid  (tx_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
   endtask

   // d = WAIT cycle index on which the RAM answers; d >= T means never
   task automatic do_txn(input bit w, input logic [7:0] a,
                         input logic [7:0] wd, input int d,
                         input logic [7:0] rd, input bit hold,
                         input bit stray);
      int rsp;
      int w0;
      int bound;
      bit in_wait;
      logic [9:0] e1;
      logic [9:0] e2;
      logic [7:0] nr;
      logic       ne;
      w0  = C2 + 1;
      rsp = w ? C2 + 1 : w0 + ((d < T) ? d : T - 1) + 1;
      nr  = (!w && d < T) ? rd : 8'h00;
      ne  = !w && d >= T;
      e1  = {w ? 2'b00 : 2'b10, a};
      e2  = w ? {2'b01, wd} : {2'b11, 8'h00};
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = wd;
      bound = 0;
      while (!req_ready && bound < 10) begin
         @(negedge clk);
         bound++;
      end
      chk("accept", req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      for (int j = 1; j <= rsp + 1; j++) begin
         @(negedge clk);
         chk("rx_valid", rx_valid, (j == 1 || j == C2) ? 1 : 0);
         if (j <= rsp) chk("din", din, (j < C2) ? e1 : e2);
         chk("rsp_valid", rsp_valid, (j == rsp) ? 1 : 0);
         chk("busy", busy, (j <= rsp) ? 1 : 0);
         chk("req_ready", req_ready, (j > rsp) ? 1 : 0);
         chk("rsp_rdata", rsp_rdata, (j >= rsp) ? nr : m_rdata);
         chk("rsp_err", rsp_err, (j >= rsp) ? ne : m_err);
         req_valid = hold && j <= rsp;
         if (hold) begin
            req_write = 1'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 8'($urandom);
         end
         in_wait = !w && j >= w0 && j < rsp;
         if (!w && d < T && j == w0 + d) begin
            tx_valid = 1'b1;
            dout     = rd;
         end else if (!in_wait && stray && $urandom_range(2) == 0) begin
            tx_valid = 1'b1;
            dout     = 8'hFF;
         end else begin
            tx_valid = 1'b0;
            dout     = 8'($urandom);
         end
      end
      tx_valid  = 1'b0;
      req_valid = 1'b0;
      m_rdata   = nr;
      m_err     = ne;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 8'h00;
      req_wdata = 8'h00;
      dout      = 8'h00;
      tx_valid  = 1'b0;
      m_rdata   = 8'h00;
      m_err     = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_din", din, 0);
      chk("rst_rx", rx_valid, 0);
      chk("rst_rspv", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);

      do_txn(1, 8'h5A, 8'h3C, 0, 8'h00, 0, 0);
      do_txn(0, 8'h5A, 8'h00, 2, 8'hA7, 0, 0);
      do_txn(0, 8'h33, 8'h00, 1000, 8'h00, 0, 0);
      do_txn(0, 8'h44, 8'h00, T - 1, 8'h11, 0, 0);
      do_txn(0, 8'h12, 8'h00, 5, 8'h6B, 1, 1);

      // reset in the middle of a write, during the gap cycle
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'h77;
      req_wdata = 8'h88;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_din", din, 0);
      chk("mid_rst_rx", rx_valid, 0);
      chk("mid_rst_rspv", rsp_valid, 0);
      chk("mid_rst_rdata", rsp_rdata, 0);
      chk("mid_rst_err", rsp_err, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", req_ready, 0);
      @(negedge clk);
      rst     = 1'b0;
      m_rdata = 8'h00;
      m_err   = 1'b0;
      do_txn(1, 8'h00, 8'h01, 0, 8'h00, 0, 0);

      for (int i = 0; i < 80; i++) begin
         do_txn(1'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(T + 2)), 8'($urandom),
                1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
